// File: rtl/load_store_unit.sv
// Multicycle RV64I load/store unit: sized, extended loads and read-modify-write stores on 64-bit memory.
// Latency from start: load 3, sb/sh/sw 4, sd 2, fault 1. No backpressure: start is ignored while busy.
module load_store_unit #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   store_data,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic              mem_we,
    output logic [XLEN-1:0]   load_data,
    output logic              busy,
    output logic              done,
    output logic              fault
);

    typedef enum logic [2:0] {IDLE, REQ, CAP, WRITE, DONE, FAULT} state_t;

    state_t          state;
    logic [2:0]      off_q;
    logic [2:0]      funct3_q;
    logic            store_q;
    logic [XLEN-1:0] sdata_q;

    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] dw,
                                                input logic [2:0] off,
                                                input logic [2:0] f3);
        logic [XLEN-1:0] v;
        v = dw >> {off, 3'b000};
        case (f3)
            3'b000:  extract = {{56{v[7]}}, v[7:0]};
            3'b001:  extract = {{48{v[15]}}, v[15:0]};
            3'b010:  extract = {{32{v[31]}}, v[31:0]};
            3'b100:  extract = {56'd0, v[7:0]};
            3'b101:  extract = {48'd0, v[15:0]};
            3'b110:  extract = {32'd0, v[31:0]};
            default: extract = v;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] dw,
                                              input logic [2:0] off,
                                              input logic [1:0] size,
                                              input logic [XLEN-1:0] sd);
        logic [XLEN-1:0] m;
        case (size)
            2'd0:    m = 64'h0000_0000_0000_00FF;
            2'd1:    m = 64'h0000_0000_0000_FFFF;
            2'd2:    m = 64'h0000_0000_FFFF_FFFF;
            default: m = '1;
        endcase
        merge = (dw & ~(m << {off, 3'b000})) | ((sd & m) << {off, 3'b000});
    endfunction

    function automatic logic aligned(input logic [2:0] off, input logic [1:0] size);
        case (size)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = ~off[0];
            2'd2:    aligned = (off[1:0] == 2'b00);
            default: aligned = (off == 3'b000);
        endcase
    endfunction

    logic req_bad;
    assign req_bad = (is_store ? funct3[2] : (funct3 == 3'b111)) || !aligned(addr[2:0], funct3[1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            off_q     <= '0;
            funct3_q  <= '0;
            store_q   <= 1'b0;
            sdata_q   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            load_data <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done  <= 1'b0;
                    fault <= 1'b0;
                    if (start) begin
                        off_q    <= addr[2:0];
                        funct3_q <= funct3;
                        store_q  <= is_store;
                        sdata_q  <= store_data;
                        busy     <= 1'b1;
                        if (req_bad) begin
                            state <= FAULT;
                        end else if (is_store && funct3 == 3'b011) begin
                            // Full doubleword store needs no read; write goes out next cycle.
                            mem_addr  <= {addr[ADDR_W-1:3], 3'b000};
                            mem_wdata <= store_data;
                            mem_we    <= 1'b1;
                            state     <= WRITE;
                        end else begin
                            mem_addr <= {addr[ADDR_W-1:3], 3'b000};
                            state    <= REQ;
                        end
                    end
                end
                REQ: state <= CAP;
                CAP: begin
                    if (store_q) begin
                        mem_wdata <= merge(mem_rdata, off_q, funct3_q[1:0], sdata_q);
                        mem_we    <= 1'b1;
                        state     <= WRITE;
                    end else begin
                        load_data <= extract(mem_rdata, off_q, funct3_q);
                        state     <= DONE;
                    end
                end
                WRITE: begin
                    mem_we <= 1'b0;
                    state  <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                FAULT: begin
                    done  <= 1'b1;
                    fault <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboarded random/directed bench for load_store_unit against a byte-level reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [63:0] addr = 64'd0;
    logic [63:0] store_data = 64'd0;
    logic [63:0] mem_rdata = 64'd0;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_we;
    logic [63:0] load_data;
    logic        busy;
    logic        done;
    logic        fault;

    load_store_unit #(.XLEN(64), .ADDR_W(64)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
        .addr(addr), .store_data(store_data), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .load_data(load_data), .busy(busy), .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment memory: registered read, write on mem_we.
    logic [63:0] mem [0:63];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[8:3]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[8:3]];
    end

    typedef struct {logic flt; logic [63:0] ld; int lat; int start_cyc;} exp_t;
    typedef struct {logic [63:0] a; logic [63:0] d;} wr_t;
    exp_t expq[$];
    wr_t  wq[$];

    int checks = 0;
    int errors = 0;

    logic [63:0] ref_mem [0:63];
    logic [63:0] ref_ld = 64'd0;

    function automatic void model(input logic st, input logic [2:0] f3, input logic [63:0] a,
                                  input logic [63:0] d, output logic flt, output logic [63:0] ld,
                                  output logic wr, output logic [63:0] wd, output int lat);
        int n, off;
        logic [63:0] dw, val;
        n   = 1 << f3[1:0];
        off = int'(a[2:0]);
        dw  = ref_mem[a[8:3]];
        flt = (st ? (f3 >= 3'd4) : (f3 == 3'd7)) || (off % n != 0);
        ld  = ref_ld;
        wr  = 1'b0;
        wd  = dw;
        lat = 1;
        if (!flt && !st) begin
            val = 64'd0;
            for (int i = 0; i < n; i++) val |= ((dw >> (8 * (off + i))) & 64'hFF) << (8 * i);
            if (!f3[2] && n < 8 && val[8 * n - 1]) val |= ~64'd0 << (8 * n);
            ld  = val;
            lat = 3;
        end else if (!flt) begin
            for (int i = 0; i < n; i++)
                wd = (wd & ~(64'hFF << (8 * (off + i)))) | (((d >> (8 * i)) & 64'hFF) << (8 * (off + i)));
            wr  = 1'b1;
            lat = (n == 8) ? 2 : 4;
        end
    endfunction

    // Monitor: every write and every done is matched against the scoreboard.
    exp_t mon_e;
    wr_t  mon_w;
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL write: unexpected mem_we addr=%h data=%h", mem_addr, mem_wdata);
                end else begin
                    mon_w = wq.pop_front();
                    if (mem_addr !== mon_w.a || mem_wdata !== mon_w.d) begin
                        errors++;
                        $display("FAIL write: got addr=%h data=%h want addr=%h data=%h",
                                 mem_addr, mem_wdata, mon_w.a, mon_w.d);
                    end
                end
            end
            if (done) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL done: spurious done fault=%b", fault);
                end else begin
                    mon_e = expq.pop_front();
                    if (fault !== mon_e.flt || load_data !== mon_e.ld ||
                        (cyc - mon_e.start_cyc) != mon_e.lat || wq.size() != 0) begin
                        errors++;
                        $display("FAIL done: got fault=%b ld=%h lat=%0d pend_wr=%0d want fault=%b ld=%h lat=%0d",
                                 fault, load_data, cyc - mon_e.start_cyc, wq.size(),
                                 mon_e.flt, mon_e.ld, mon_e.lat);
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (expq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL timeout: no done within budget");
            expq.delete();
            wq.delete();
        end
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] d, input bit poke);
        exp_t e;
        wr_t w;
        logic wr;
        @(negedge clk);
        model(st, f3, a, d, e.flt, e.ld, wr, w.d, e.lat);
        e.start_cyc = cyc + 1;
        expq.push_back(e);
        if (wr) begin
            w.a = {a[63:3], 3'b000};
            wq.push_back(w);
            ref_mem[a[8:3]] = w.d;
        end
        ref_ld = e.ld;
        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = d;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy: got %b want 1", busy);
        end
        if (poke) begin
            start = 1'b1; is_store = 1'b0; funct3 = 3'd3; addr = 64'h20;
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        logic [2:0]  f3;
        logic [63:0] a;
        bit ok;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = {$urandom, $urandom};
            mem[i] = ref_mem[i];
        end
        ref_mem[2] = 64'h8877665544332211;
        mem[2] = 64'h8877665544332211;

        #1;
        checks++;
        if ({mem_addr, mem_wdata, mem_we, load_data, busy, done, fault} !== '0) begin
            errors++;
            $display("FAIL reset: outputs not zero we=%b busy=%b done=%b ld=%h", mem_we, busy, done, load_data);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;

        issue(1'b0, 3'd3, 64'h10, 64'd0, 1'b0);                   // ld
        issue(1'b0, 3'd0, 64'h17, 64'd0, 1'b1);                   // lb, second start while busy
        issue(1'b0, 3'd4, 64'h17, 64'd0, 1'b0);                   // lbu
        issue(1'b0, 3'd2, 64'h14, 64'd0, 1'b0);                   // lw
        issue(1'b0, 3'd5, 64'h12, 64'd0, 1'b0);                   // lhu
        issue(1'b1, 3'd0, 64'h12, 64'h1234_5678_9ABC_DEAB, 1'b0); // sb
        issue(1'b1, 3'd3, 64'h20, 64'hDEADBEEFCAFEF00D, 1'b0);    // sd
        issue(1'b1, 3'd1, 64'h13, 64'h5555, 1'b0);                // misaligned sh
        issue(1'b1, 3'd4, 64'h08, 64'h1, 1'b0);                   // illegal store
        issue(1'b0, 3'd7, 64'h08, 64'h0, 1'b0);                   // illegal load

        // sw interrupted by reset while its write is on the bus.
        begin
            wr_t w;
            @(negedge clk);
            w.a = 64'h18;
            w.d = (ref_mem[3] & 64'hFFFF_FFFF_0000_0000) | 64'h0000_0000_A5A5_5A5A;
            wq.push_back(w);
            start = 1'b1; is_store = 1'b1; funct3 = 3'd2; addr = 64'h18; store_data = 64'h1111_2222_A5A5_5A5A;
            @(negedge clk);
            start = 1'b0;
            ok = 1'b0;
            for (int k = 0; k < 10; k++) begin
                #2;
                if (mem_we) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rst_mid: write never appeared");
            end
            rst = 1'b1;
            #1;
            checks++;
            if ({mem_addr, mem_wdata, mem_we, load_data, busy, done, fault} !== '0) begin
                errors++;
                $display("FAIL rst_mid: outputs not zero we=%b busy=%b ld=%h", mem_we, busy, load_data);
            end
            wq.delete();
            ref_ld = 64'd0;
            @(negedge clk);
            rst = 1'b0;
        end
        issue(1'b0, 3'd3, 64'h10, 64'd0, 1'b0);
        issue(1'b0, 3'd3, 64'h18, 64'd0, 1'b0);

        for (int t = 0; t < 300; t++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = 64'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
            issue(1'($urandom_range(0, 1)), f3, a, {$urandom, $urandom}, ($urandom_range(0, 7) == 0));
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
